// File: rtl/digit_serial_adder.sv
// ============================================================================
// Module   : digit_serial_adder
// Purpose  : WIDTH-bit adder that processes DIGIT bits per clock through one
//            registered-carry ripple chain, with a start/done handshake.
//            Optional macro SUBTRACT_EN adds a 'sub' input (a - b).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  int               w_base;
  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DIGIT-1:0] w_dsum;
  logic [DIGIT:0]   w_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_comb begin
    w_base = int'(r_cnt) * DIGIT;
    w_da   = r_a[w_base +: DIGIT];
    w_db   = r_b[w_base +: DIGIT];
  end

  // One digit-wide ripple chain, fed by the carry left over from the previous digit
  assign w_c[0] = r_carry;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign w_dsum[gi]  = w_da[gi] ^ w_db[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (w_da[gi] & w_db[gi]) | (w_c[gi] & (w_da[gi] ^ w_db[gi]));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
`ifdef SUBTRACT_EN
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : ci;
`else
      r_b     <= b;
      r_carry <= ci;
`endif
      r_cnt <= '0;
      r_s   <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == RUN) begin
      r_s[w_base +: DIGIT] <= w_dsum;
      r_carry              <= w_c[DIGIT];
      if (w_last) begin
        // carry into the MSB is w_c[DIGIT-1] on the final digit
        r_co  <= w_c[DIGIT];
        r_ovf <= w_c[DIGIT] ^ w_c[DIGIT-1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
// ============================================================================
// Module   : tb_digit_serial_adder
// Purpose  : Scoreboard bench for digit_serial_adder with a reference model
//            built from plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_digit_serial_adder;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef SUBTRACT_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    int               dcyc;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  exp_t got;
  int   cyc       = 0;
  int   next_free = 0;
  int   last_acc  = 0;
  bit   has_acc   = 1'b0;
  bit   eb;
  bit   ed;
  int   checks    = 0;
  int   errors    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: unsigned result from integer sum, overflow from signed range
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic cin, input logic sb, input int e);
    exp_t m;
    int ux, uy, uc, tot, sx, sy, stot;
    ux   = int'(x);
    uy   = sb ? ((2 ** WIDTH) - 1 - int'(y)) : int'(y);
    uc   = sb ? 1 : int'(cin);
    tot  = ux + uy + uc;
    m.s  = WIDTH'(tot);
    m.co = (tot >= (2 ** WIDTH));
    sx   = x[WIDTH-1] ? int'(x) - (2 ** WIDTH) : int'(x);
    sy   = y[WIDTH-1] ? int'(y) - (2 ** WIDTH) : int'(y);
    stot = sb ? (sx - sy) : (sx + sy + int'(cin));
    m.ovf  = (stot > (2 ** (WIDTH - 1)) - 1) || (stot < -(2 ** (WIDTH - 1)));
    m.dcyc = e + NDIG + 1;
    return m;
  endfunction

  // Acceptance model: one request per NDIG+1 edges, reset flushes everything
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sbq.delete();
      has_acc   = 1'b0;
      next_free = 0;
    end else begin
      if (start && cyc >= next_free) begin
`ifdef SUBTRACT_EN
        cur = model(a, b, ci, sub, cyc);
`else
        cur = model(a, b, ci, 1'b0, cyc);
`endif
        sbq.push_back(cur);
        has_acc   = 1'b1;
        last_acc  = cyc;
        next_free = cyc + NDIG + 1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      eb = has_acc && (cyc > last_acc) && (cyc <= last_acc + NDIG);
      ed = has_acc && (cyc == last_acc + NDIG + 1);
      chk("busy", 32'(busy), 32'(eb));
      chk("done_timing", 32'(done), 32'(ed));
      if (has_acc && cyc == last_acc + 1) chk("s_cleared", 32'(s), 32'd0);
      if (has_acc && !eb) chk("s_hold", 32'(s), 32'(cur.s));
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_extra: done with empty scoreboard (cycle %0d)", cyc);
        end else begin
          got = sbq.pop_front();
          chk("sum", 32'(s), 32'(got.s));
          chk("carry_out", 32'(co), 32'(got.co));
          chk("overflow", 32'(ovf), 32'(got.ovf));
          chk("latency", 32'(cyc), 32'(got.dcyc));
        end
      end
    end
  end

  task automatic op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin);
    @(negedge clk);
    start = 1'b1; a = x; b = y; ci = cin;
    @(negedge clk);
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
    repeat (NDIG + 2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_co", 32'(co), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    op(8'h5A, 8'h3C, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'h7F, 8'h00, 1'b1);

    // start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; ci = 1'b0;
    repeat (4 * (NDIG + 1)) @(negedge clk);
    start = 1'b0;
    repeat (NDIG + 2) @(negedge clk);

    // start while busy must be ignored
    start = 1'b1; a = 8'h12; b = 8'h34; ci = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (NDIG + 2) @(negedge clk);

    // reset during the second RUN cycle aborts without a done pulse
    start = 1'b1; a = 8'h55; b = 8'h55; ci = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_co", 32'(co), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (NDIG + 2) @(negedge clk);
    op(8'h0F, 8'h01, 1'b0);

`ifdef SUBTRACT_EN
    sub = 1'b1;
    op(8'h10, 8'h20, 1'b0);
    op(8'h80, 8'h01, 1'b0);
    sub = 1'b0;
`endif

    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      ci    = 1'($urandom);
`ifdef SUBTRACT_EN
      sub   = 1'($urandom);
`endif
    end
    @(negedge clk);
    start = 1'b0;
    repeat (NDIG + 3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
